// File: rtl/filter_decimator.sv
`default_nettype none
// ============================================================================
// Module   : filter_decimator
// Purpose  : Boxcar average and decimate-by-DECIM of a sample stream, with a
//            valid/ready output register. `FILTER_DECIM_ROUND_EN selects
//            round-half-up with saturation; the default truncates.
// Revision : 1.0  initial release
// ============================================================================
module filter_decimator #(
   parameter int DW       = 16,
   parameter int LOG2_DEC = 2,
   parameter int BCW      = (LOG2_DEC > 0) ? LOG2_DEC : 1
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           in_valid,
   input  logic [DW-1:0]  in_data,
   input  logic           flush,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [DW-1:0]  out_data,
   output logic           overrun,
   output logic [BCW-1:0] blk_cnt
);

   localparam int             DECIM  = 1 << LOG2_DEC;
   localparam int             AW     = DW + LOG2_DEC + 1;
   localparam logic [BCW-1:0] C_LAST = BCW'(DECIM - 1);

   typedef enum logic [0:0] {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [AW-1:0]  acc_q, acc_d;
   logic [BCW-1:0] cnt_q, cnt_d;
   logic [DW-1:0]  data_q, data_d;
   logic           ovr_q, ovr_d;

   logic [AW-1:0]  w_base_acc;
   logic [AW-1:0]  w_sum;
   logic [BCW-1:0] w_base_cnt;
   logic           w_blk_end;
   logic [DW-1:0]  w_result;

   // A flush empties the window before the current sample is considered,
   // so a coincident sample becomes the first of the new window.
   always_comb begin
      w_base_acc = flush ? '0 : acc_q;
      w_base_cnt = flush ? '0 : cnt_q;
      w_sum      = w_base_acc + AW'(in_data);
      w_blk_end  = in_valid && (w_base_cnt == C_LAST);
      acc_d      = w_base_acc;
      cnt_d      = w_base_cnt;
      if (in_valid) begin
         if (w_blk_end) begin
            acc_d = '0;
            cnt_d = '0;
         end else begin
            acc_d = w_sum;
            cnt_d = w_base_cnt + 1'b1;
         end
      end
   end

`ifdef FILTER_DECIM_ROUND_EN
   localparam logic [AW-1:0] C_MAX = {{(LOG2_DEC + 1){1'b0}}, {DW{1'b1}}};
   logic [AW-1:0] w_rnd;

   always_comb begin
      w_rnd    = (w_sum + AW'(DECIM / 2)) >> LOG2_DEC;
      w_result = (w_rnd > C_MAX) ? '1 : DW'(w_rnd);
   end
`else
   always_comb begin
      w_result = DW'(w_sum >> LOG2_DEC);
   end
`endif

   // A result completing while FULL replaces the held one only if the held
   // one is being consumed on the same edge; otherwise it is lost.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      ovr_d   = ovr_q;
      case (state_q)
         S_EMPTY: begin
            if (w_blk_end) begin
               state_d = S_FULL;
               data_d  = w_result;
            end
         end
         S_FULL: begin
            if (w_blk_end) begin
               if (out_ready) data_d = w_result;
               else           ovr_d  = 1'b1;
            end else if (out_ready) begin
               state_d = S_EMPTY;
            end
         end
         default: state_d = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_EMPTY;
         acc_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         ovr_q   <= ovr_d;
      end
   end

   assign out_valid = (state_q == S_FULL);
   assign out_data  = data_q;
   assign overrun   = ovr_q;
   assign blk_cnt   = cnt_q;

endmodule
`default_nettype wire
